// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: turns TLBR/TLBWI/TLBWR/TLBP requests into timed
// accesses on the MMU maintenance port and owns the Random and Wired registers.

package tlb_op_ctrl_pkg;

  typedef struct packed {
    logic [31:0] entry_hi;
    logic [31:0] page_mask;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'b00,
    OP_TLBWI = 2'b01,
    OP_TLBWR = 2'b10,
    OP_TLBP  = 2'b11
  } tlb_op_t;

endpackage

module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  input  logic             flush,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [31:0]      cp0_entry_hi,
  input  tlb_entry_t       cp0_wdata,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_wdata,
  output logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random,
  output logic             done,
  output logic             rd_valid,
  output tlb_entry_t       rd_entry,
  output logic             probe_valid,
  output logic [31:0]      probe_index,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output tlb_entry_t       tlbrw_wdata,
  input  tlb_entry_t       tlbrw_rdata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_PROBE,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  tlb_op_t          op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      ehi_q, ehi_d;
  tlb_entry_t       wdata_q, wdata_d;
  tlb_entry_t       rd_entry_q, rd_entry_d;
  logic [31:0]      probe_index_q, probe_index_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [IDX_W-1:0] wired_q, wired_d;

  // Random wraps to the top whenever it reaches Wired (or zero), so it never
  // hands out a wired entry.
  always_comb begin
    random_d = random_q;
    wired_d  = wired_q;
    if (wired_we) begin
      random_d = MAX_IDX;
      wired_d  = wired_wdata;
    end else if (random_q == wired_q || random_q == '0) begin
      random_d = MAX_IDX;
    end else begin
      random_d = random_q - IDX_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    idx_d         = idx_q;
    ehi_d         = ehi_q;
    wdata_d       = wdata_q;
    rd_entry_d    = rd_entry_q;
    probe_index_d = probe_index_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d    = tlb_op_t'(op_type);
          idx_d   = (tlb_op_t'(op_type) == OP_TLBWR) ? random_q : cp0_index;
          ehi_d   = cp0_entry_hi;
          wdata_d = cp0_wdata;
          case (tlb_op_t'(op_type))
            OP_TLBR:  state_d = S_READ;
            OP_TLBP:  state_d = S_PROBE;
            default:  state_d = S_WRITE;
          endcase
        end
      end
      S_READ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rd_entry_d = tlbrw_rdata;
          state_d    = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_PROBE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          probe_index_d = tlbp_index;
          state_d       = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_TLBR;
      idx_q         <= '0;
      ehi_q         <= '0;
      wdata_q       <= '0;
      rd_entry_q    <= '0;
      probe_index_q <= '0;
      random_q      <= MAX_IDX;
      wired_q       <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      ehi_q         <= ehi_d;
      wdata_q       <= wdata_d;
      rd_entry_q    <= rd_entry_d;
      probe_index_q <= probe_index_d;
      random_q      <= random_d;
      wired_q       <= wired_d;
    end
  end

  // Every output is a flop or a pure decode of state, so reset clears them at once.
  assign op_ready      = (state_q == S_IDLE);
  assign tlbrw_we      = (state_q == S_WRITE);
  assign done          = (state_q == S_RESP);
  assign rd_valid      = done && (op_q == OP_TLBR);
  assign probe_valid   = done && (op_q == OP_TLBP);
  assign rd_entry      = rd_entry_q;
  assign probe_index   = probe_index_q;
  assign tlbrw_index   = idx_q;
  assign tlbrw_wdata   = wdata_q;
  assign tlbp_entry_hi = ehi_q;
  assign random        = random_q;
  assign wired         = wired_q;

endmodule
